// File: rtl/riscv_single_cycle_core.sv
// riscv_single_cycle_core: single-cycle RV32I-subset processor.
// Supports add, sub, or, and, addi, ori, lw, sw and beq; fetch, decode,
// execute, memory access and writeback all complete in one clock.
// Optional feature macro: RV_BNE_EN adds bne (branch funct3 001); without
// it, funct3 001 branches behave as NOPs.
// Note: rst_n is an ACTIVE-HIGH synchronous reset despite its name.

// Instruction ROM, read combinationally; contents are preloaded externally
module riscv_imem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    logic [31:0] InstructionMem [0:DEPTH-1];

    assign rdata = InstructionMem[addr];
endmodule

// 32x32 register file: two asynchronous reads, one synchronous write, x0 fixed at zero
module riscv_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] RF [0:31];

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : RF[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : RF[raddr2];

    // Register write on the rising edge; writes aimed at x0 are dropped
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            RF[waddr] <= wdata;
        end
    end
endmodule

// Word-addressed data RAM: asynchronous read, synchronous write
module riscv_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] DataMem [0:DEPTH-1];

    assign rdata = DataMem[addr];

    // Store the word on the rising edge when a sw executes
    always_ff @(posedge clk) begin
        if (we) begin
            DataMem[addr] <= wdata;
        end
    end
endmodule

// Processor top: PC, decode, ALU and the three memories
module riscv_single_cycle_core #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] Instruction
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [IAW-1:0] imem_addr;
    logic [DAW-1:0] dmem_addr;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;

    logic [31:0]  imm_i;
    logic [31:0]  imm_s;
    logic [31:0]  imm_b;

    logic [31:0]  rs1_val;
    logic [31:0]  rs2_val;
    logic [31:0]  alu_b;
    logic [31:0]  alu_result;
    logic         alu_zero;
    logic [31:0]  dmem_rdata;
    logic [31:0]  wb_data;

    alu_op_t      alu_op;
    logic         reg_write;
    logic         mem_write;
    logic         use_imm_i;
    logic         use_imm_s;
    logic         wb_from_mem;
    logic         branch_on_eq;
    logic         branch_on_ne;
    logic         branch_taken;

    assign imem_addr = IAW'((pc >> 2) % 32'(IMEM_DEPTH));

    assign opcode = Instruction[6:0];
    assign rd     = Instruction[11:7];
    assign funct3 = Instruction[14:12];
    assign rs1    = Instruction[19:15];
    assign rs2    = Instruction[24:20];
    assign funct7 = Instruction[31:25];

    assign imm_i = {{20{Instruction[31]}}, Instruction[31:20]};
    assign imm_s = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
    assign imm_b = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                    Instruction[30:25], Instruction[11:8], 1'b0};

    riscv_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) instructionMem (
        .addr  (imem_addr),
        .rdata (Instruction)
    );

    riscv_regfile RF (
        .clk    (clk),
        .we     (reg_write & ~rst_n),
        .waddr  (rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    riscv_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) DataMem (
        .clk   (clk),
        .we    (mem_write & ~rst_n),
        .addr  (dmem_addr),
        .wdata (rs2_val),
        .rdata (dmem_rdata)
    );

    // Decode the fetched word into control signals; anything unrecognised stays a NOP
    always_comb begin
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        use_imm_i    = 1'b0;
        use_imm_s    = 1'b0;
        wb_from_mem  = 1'b0;
        branch_on_eq = 1'b0;
        branch_on_ne = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            reg_write = 1'b1;
                            alu_op    = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            reg_write = 1'b1;
                            alu_op    = ALU_SUB;
                        end
                    end
                    3'b110: begin
                        reg_write = 1'b1;
                        alu_op    = ALU_OR;
                    end
                    3'b111: begin
                        reg_write = 1'b1;
                        alu_op    = ALU_AND;
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    reg_write = 1'b1;
                    use_imm_i = 1'b1;
                    alu_op    = ALU_ADD;
                end else if (funct3 == 3'b110) begin
                    reg_write = 1'b1;
                    use_imm_i = 1'b1;
                    alu_op    = ALU_OR;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    reg_write   = 1'b1;
                    use_imm_i   = 1'b1;
                    wb_from_mem = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    mem_write = 1'b1;
                    use_imm_s = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    branch_on_eq = 1'b1;
                    alu_op       = ALU_SUB;
                end
`ifdef RV_BNE_EN
                else if (funct3 == 3'b001) begin
                    branch_on_ne = 1'b1;
                    alu_op       = ALU_SUB;
                end
`endif
            end
            default: ;
        endcase
    end

    assign alu_b = use_imm_i ? imm_i : (use_imm_s ? imm_s : rs2_val);

    // 32-bit wrapping ALU; the zero result drives the branch compare
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = rs1_val + alu_b;
            ALU_SUB: alu_result = rs1_val - alu_b;
            ALU_OR:  alu_result = rs1_val | alu_b;
            ALU_AND: alu_result = rs1_val & alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    assign alu_zero     = (alu_result == 32'd0);
    assign branch_taken = (branch_on_eq & alu_zero) | (branch_on_ne & ~alu_zero);
    assign dmem_addr    = DAW'((alu_result >> 2) % 32'(DMEM_DEPTH));
    assign wb_data      = wb_from_mem ? dmem_rdata : alu_result;
    assign pc_next      = branch_taken ? (pc + imm_b) : (pc + 32'd4);

    // Program counter: cleared by the active-high reset, otherwise follows the next-PC mux
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc <= 32'd0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Testbench for riscv_single_cycle_core: table of single-instruction vectors
// plus hand-written reset and back-to-back sequences. Every IMEM word that
// is not under test holds a unique unsupported-opcode marker, so the
// Instruction output identifies the current PC.
module tb_riscv_single_cycle_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] Instruction;

    int tests = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] inst;
        int          startIdx;
        int          ra;
        logic [31:0] va;
        int          rb;
        logic [31:0] vb;
        int          memIdx;
        logic [31:0] memVal;
        int          chkReg;
        logic [31:0] expReg;
        int          expMemIdx;
        logic [31:0] expMem;
        int          expNext;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

`ifdef RV_BNE_EN
    localparam int BNE_NEXT = 4;
`else
    localparam int BNE_NEXT = 3;
`endif

    riscv_single_cycle_core #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Instruction (Instruction)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [31:0] marker(input int k);
        logic [5:0] kk;
        kk = k[5:0];
        return {20'hABCDE, kk, 6'h3F};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] rdst);
        return {f7, r2, r1, f3, rdst, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rdst,
                                         input logic [6:0] op);
        return {imm, r1, f3, rdst, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] r2,
                                         input logic [4:0] r1);
        return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearMemories();
        for (int i = 0; i < 64; i++) begin
            dut.instructionMem.InstructionMem[i] = marker(i);
            dut.DataMem.DataMem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) begin
            dut.RF.RF[i] = 32'd0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n = 1'b1;
        clearMemories();
        dut.instructionMem.InstructionMem[v.startIdx] = v.inst;
        dut.RF.RF[v.ra] = v.va;
        dut.RF.RF[v.rb] = v.vb;
        dut.DataMem.DataMem[v.memIdx] = v.memVal;
        step();
        rst_n = 1'b0;
        for (int i = 0; i < v.startIdx; i++) begin
            step();
        end
        checkOutput({v.name, "_fetch"}, Instruction, v.inst);
        step();
        checkOutput({v.name, "_reg"}, dut.RF.RF[v.chkReg], v.expReg);
        checkOutput({v.name, "_mem"}, dut.DataMem.DataMem[v.expMemIdx], v.expMem);
        checkOutput({v.name, "_nextpc"}, Instruction, marker(v.expNext));
    endtask

    initial begin
        //            name       inst                                          st ra va            rb vb            mi mv            cr er            emi em            nx
        vecs[0]  = '{"add",      encR(7'h00, 5'd25, 5'd16, 3'b000, 5'd13),     0, 16, 32'd5,       25, 32'd7,       0, 32'd0,        13, 32'd12,       0, 32'd0,         1};
        vecs[1]  = '{"sub",      encR(7'h20, 5'd3, 5'd8, 3'b000, 5'd5),        0, 8,  32'd3,       3,  32'd10,      0, 32'd0,        5,  32'hFFFFFFF9, 0, 32'd0,         1};
        vecs[2]  = '{"and",      encR(7'h00, 5'd3, 5'd2, 3'b111, 5'd1),        0, 2,  32'hF0,      3,  32'h3C,      0, 32'd0,        1,  32'h30,       0, 32'd0,         1};
        vecs[3]  = '{"or",       encR(7'h00, 5'd5, 5'd14, 3'b110, 5'd4),       0, 14, 32'hA5,      5,  32'h5A0,     0, 32'd0,        4,  32'h5A5,      0, 32'd0,         1};
        vecs[4]  = '{"addi",     encI(12'd3, 5'd21, 3'b000, 5'd22, 7'h13),     0, 21, 32'd1,       0,  32'd0,       0, 32'd0,        22, 32'd4,        0, 32'd0,         1};
        vecs[5]  = '{"ori",      encI(12'd1, 5'd8, 3'b110, 5'd9, 7'h13),       0, 8,  32'd2,       0,  32'd0,       0, 32'd0,        9,  32'd3,        0, 32'd0,         1};
        vecs[6]  = '{"lw",       encI(12'd31, 5'd5, 3'b010, 5'd8, 7'h03),      0, 5,  32'd1,       0,  32'd0,       8, 32'hDEADBEEF, 8,  32'hDEADBEEF, 8, 32'hDEADBEEF,  1};
        vecs[7]  = '{"sw",       encS(12'd12, 5'd15, 5'd5),                    0, 5,  32'd4,       15, 32'h12345678, 0, 32'd0,       12, 32'd0,        4, 32'h12345678,  1};
        vecs[8]  = '{"beq_tk",   encB(13'd12, 5'd9, 5'd9, 3'b000),             10, 9, 32'd3,       0,  32'd0,       0, 32'd0,        9,  32'd3,        0, 32'd0,         13};
        vecs[9]  = '{"beq_nt",   encB(13'd12, 5'd10, 5'd9, 3'b000),            10, 9, 32'd3,       10, 32'd4,       0, 32'd0,        9,  32'd3,        0, 32'd0,         11};
        vecs[10] = '{"beq_back", encB(13'h1FF8, 5'd9, 5'd9, 3'b000),           5, 9,  32'd3,       0,  32'd0,       0, 32'd0,        9,  32'd3,        0, 32'd0,         3};
        vecs[11] = '{"x0_write", encI(12'd5, 5'd21, 3'b000, 5'd0, 7'h13),      0, 21, 32'd1,       0,  32'd0,       0, 32'd0,        0,  32'd0,        0, 32'd0,         1};
        vecs[12] = '{"nop_zero", 32'h00000000,                                 0, 1,  32'h11,      0,  32'd0,       0, 32'd0,        1,  32'h11,       0, 32'd0,         1};
        vecs[13] = '{"add_wrap", encR(7'h00, 5'd7, 5'd7, 3'b000, 5'd6),        0, 7,  32'h80000000, 0, 32'd0,       0, 32'd0,        6,  32'd0,        0, 32'd0,         1};
        vecs[14] = '{"bad_f7",   encR(7'h01, 5'd3, 5'd8, 3'b000, 5'd5),        0, 8,  32'd3,       3,  32'd10,      0, 32'd0,        5,  32'd0,        0, 32'd0,         1};
        vecs[15] = '{"lw_wrap",  encI(12'd0, 5'd5, 3'b010, 5'd8, 7'h03),       0, 5,  32'd256,     0,  32'd0,       0, 32'hCAFEF00D, 8,  32'hCAFEF00D, 0, 32'hCAFEF00D,  1};
        vecs[16] = '{"bne",      encB(13'd8, 5'd10, 5'd9, 3'b001),             2, 9,  32'd3,       10, 32'd4,       0, 32'd0,        9,  32'd3,        0, 32'd0,         BNE_NEXT};
        vecs[17] = '{"lw_badf3", encI(12'd0, 5'd5, 3'b000, 5'd8, 7'h03),       0, 5,  32'd0,       0,  32'd0,       0, 32'h77,       8,  32'd0,        0, 32'h77,        1};
        vecs[18] = '{"addi_neg", encI(12'hFFF, 5'd0, 3'b000, 5'd3, 7'h13),     0, 0,  32'd0,       0,  32'd0,       0, 32'd0,        3,  32'hFFFFFFFF, 0, 32'd0,         1};
        vecs[19] = '{"sw_neg",   encS(12'hFFC, 5'd15, 5'd5),                   0, 5,  32'd12,      15, 32'hA5A5A5A5, 0, 32'd0,       0,  32'd0,        2, 32'hA5A5A5A5,  1};

        // Reset with IMEM[0]=0, then one step after release
        clearMemories();
        dut.instructionMem.InstructionMem[0] = 32'd0;
        rst_n = 1'b1;
        step();
        checkOutput("reset_inst", Instruction, 32'd0);
        rst_n = 1'b0;
        step();
        checkOutput("post_reset_step", Instruction, marker(1));

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back dependency: new register value visible on the following cycle
        rst_n = 1'b1;
        clearMemories();
        dut.instructionMem.InstructionMem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
        dut.instructionMem.InstructionMem[1] = encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
        step();
        rst_n = 1'b0;
        step();
        checkOutput("dep_x1", dut.RF.RF[1], 32'd5);
        step();
        checkOutput("dep_x2", dut.RF.RF[2], 32'd10);

        // Mid-run reset: writes suppressed while in reset, memories preserved
        rst_n = 1'b1;
        clearMemories();
        dut.RF.RF[3] = 32'h55;
        dut.DataMem.DataMem[2] = 32'h66;
        dut.instructionMem.InstructionMem[0] = encI(12'd99, 5'd0, 3'b000, 5'd7, 7'h13);
        dut.instructionMem.InstructionMem[4] = encS(12'd8, 5'd3, 5'd0);
        step();
        checkOutput("rst_no_rfwrite", dut.RF.RF[7], 32'd0);
        rst_n = 1'b0;
        step();
        checkOutput("run_addi", dut.RF.RF[7], 32'd99);
        step();
        step();
        step();
        checkOutput("at_pc_0x10", Instruction, encS(12'd8, 5'd3, 5'd0));
        rst_n = 1'b1;
        step();
        checkOutput("midrst_pc0", Instruction, encI(12'd99, 5'd0, 3'b000, 5'd7, 7'h13));
        checkOutput("midrst_no_sw", dut.DataMem.DataMem[2], 32'h66);
        checkOutput("midrst_rf3", dut.RF.RF[3], 32'h55);
        checkOutput("midrst_rf7", dut.RF.RF[7], 32'd99);
        rst_n = 1'b0;
        step();
        checkOutput("midrst_resume", Instruction, marker(1));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
